tm1638_keys: RTL and testbench



---
 rtl/tm1638_keys_if.sv | 61 ++++++
 rtl/tm1638_keys.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_tm1638_keys.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_keys_if.sv
// tm1638_keys_if
// Bundles every non-clock signal of the TM1638 key-scan reader: the host-side
// request/result handshake and the STB/CLK/DIO link toward the pad ring.
//
// Signals
//   start      host -> reader  request one key scan
//   busy       reader -> host  scan in progress (through the valid cycle)
//   valid      reader -> host  one-cycle result strobe
//   key_raw    reader -> host  32 scanned bits, byte0 in [7:0]
//   keys       reader -> host  8 button states, 1 = pressed
//   key_press  reader -> host  newly-pressed mask, non-zero only with valid
//   stb        reader -> pad   TM1638 STB, active-low
//   sclk       reader -> pad   TM1638 CLK, idles high
//   dio_out    reader -> pad   DIO drive value
//   dio_oe     reader -> pad   1 = reader drives DIO
//   dio_in     pad -> reader   DIO pad input (asynchronous)
//
// Modports
//   master : the requester / pad side (drives start and dio_in)
//   slave  : the key-scan reader itself
interface tm1638_keys_if;
  logic        start;
  logic        busy;
  logic        valid;
  logic [31:0] key_raw;
  logic [7:0]  keys;
  logic [7:0]  key_press;
  logic        stb;
  logic        sclk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;

  modport master (
    output start,
    output dio_in,
    input  busy,
    input  valid,
    input  key_raw,
    input  keys,
    input  key_press,
    input  stb,
    input  sclk,
    input  dio_out,
    input  dio_oe
  );

  modport slave (
    input  start,
    input  dio_in,
    output busy,
    output valid,
    output key_raw,
    output keys,
    output key_press,
    output stb,
    output sclk,
    output dio_out,
    output dio_oe
  );
endinterface

// File: rtl/tm1638_keys.sv
// tm1638_keys
// Key-scan reader for the TM1638 LED&KEY board. On a start request it pulls
// STB low, shifts out the read-key command 0x42 LSB first, turns the DIO bus
// around, clocks in the four key-scan bytes and publishes the eight button
// states together with a newly-pressed mask.
//
// Parameters
//   CLK_DIV      system clocks per SCLK half-period (>= 3)
//   WAIT_CYCLES  system clocks between command byte and first read bit (>= 1)
//
// Ports
//   clk1   system clock, rising edge
//   reset  synchronous, active-low
//   kif    tm1638_keys_if.slave (start/busy/valid/results and STB/CLK/DIO)
//
// Scan length is 82*CLK_DIV + WAIT_CYCLES cycles: SETUP (1 half-period),
// CMD (16 half-periods), WAIT, READ (64 half-periods), END (1 half-period).
// All link and result outputs are registered; their next values are decoded
// from the next-state vector so each register already holds the value that
// belongs to the state being entered.
module tm1638_keys #(
  parameter int CLK_DIV     = 4,
  parameter int WAIT_CYCLES = 8
) (
  input  logic         clk1,
  input  logic         reset,
  tm1638_keys_if.slave kif
);

  localparam int CNT_MAX = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  localparam logic [7:0] READ_CMD      = 8'h42;
  localparam logic [4:0] CMD_LAST_BIT  = 5'd7;
  localparam logic [4:0] READ_LAST_BIT = 5'd31;

  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_END   = 3'd5
  } state_t;

  // Button i (0..3) is bit 0 of scan byte i; button i+4 is bit 4 of byte i.
  function automatic logic [7:0] map_keys(input logic [31:0] raw);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = raw[8*i];
      k[i + 4] = raw[8*i + 4];
    end
    return k;
  endfunction

  // Sequencer state
  state_t            state_r;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_n;
  logic [4:0]        bit_r;
  logic [4:0]        bit_n;
  logic              phase_r;
  logic              phase_n;
  logic [31:0]       shift_r;
  logic [31:0]       shift_n;
  logic              div_end_s;
  logic [4:0]        last_bit_s;

  // DIO input synchronizer
  logic              sync1_r;
  logic              sync2_r;

  // Registered outputs and their next values
  logic              stb_r;
  logic              sclk_r;
  logic              dio_out_r;
  logic              dio_oe_r;
  logic              busy_r;
  logic              valid_r;
  logic [31:0]       key_raw_r;
  logic [7:0]        keys_r;
  logic [7:0]        key_press_r;
  logic              stb_n;
  logic              sclk_n;
  logic              dio_out_n;
  logic              dio_oe_n;
  logic              busy_n;
  logic              publish_s;
  logic [7:0]        keys_new_s;

  // State register, phase/bit counters and receive shift register
  always_ff @(posedge clk1) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 5'd0;
      phase_r <= PH_HIGH;
      shift_r <= 32'h0000_0000;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bit_r   <= bit_n;
      phase_r <= phase_n;
      shift_r <= shift_n;
    end
  end

  // Next-state logic: half-period timing, bit counting and read capture
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    bit_n      = bit_r;
    phase_n    = phase_r;
    shift_n    = shift_r;
    div_end_s  = (cnt_r == DIV_LAST);
    last_bit_s = (state_r == ST_CMD) ? CMD_LAST_BIT : READ_LAST_BIT;

    case (state_r)
      ST_IDLE: begin
        cnt_n   = CNT_ZERO;
        bit_n   = 5'd0;
        phase_n = PH_HIGH;
        if (kif.start) begin
          state_n = ST_SETUP;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (div_end_s) begin
          state_n = ST_CMD;
          cnt_n   = CNT_ZERO;
          bit_n   = 5'd0;
          phase_n = PH_LOW;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      // CMD and READ share the low/high half-period structure; only the
      // bit count, the capture and the follow-on state differ.
      ST_CMD, ST_READ: begin
        if (div_end_s) begin
          cnt_n = CNT_ZERO;
          if (phase_r == PH_HIGH) begin
            // Last cycle of a high phase: sample DIO, first bit lands in [0].
            if (state_r == ST_READ) begin
              shift_n = {sync2_r, shift_r[31:1]};
            end else begin
              shift_n = shift_r;
            end
            if (bit_r == last_bit_s) begin
              state_n = (state_r == ST_CMD) ? ST_WAIT : ST_END;
              bit_n   = 5'd0;
              phase_n = PH_HIGH;
            end else begin
              bit_n   = bit_r + 5'd1;
              phase_n = PH_LOW;
            end
          end else begin
            phase_n = PH_HIGH;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_n = ST_READ;
          cnt_n   = CNT_ZERO;
          bit_n   = 5'd0;
          phase_n = PH_LOW;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      ST_END: begin
        if (div_end_s) begin
          state_n = ST_IDLE;
          cnt_n   = CNT_ZERO;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = CNT_ZERO;
        bit_n   = 5'd0;
        phase_n = PH_HIGH;
      end
    endcase
  end

  // Output decode from the next-state vector, so registers track the state entered
  always_comb begin
    stb_n     = 1'b1;
    sclk_n    = 1'b1;
    dio_oe_n  = 1'b0;
    dio_out_n = 1'b0;
    busy_n    = 1'b1;

    case (state_n)
      ST_IDLE: begin
        busy_n = 1'b0;
      end
      ST_SETUP: begin
        stb_n    = 1'b0;
        dio_oe_n = 1'b1;
      end
      ST_CMD: begin
        stb_n     = 1'b0;
        sclk_n    = phase_n;
        dio_oe_n  = 1'b1;
        // bit_n only advances when a low phase starts, so the data bit is
        // set up on the falling SCLK edge and held through the high phase.
        dio_out_n = READ_CMD[bit_n[2:0]];
      end
      ST_WAIT: begin
        stb_n = 1'b0;
      end
      ST_READ: begin
        stb_n  = 1'b0;
        sclk_n = phase_n;
      end
      ST_END: begin
        stb_n = 1'b1;
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase

    // Results go out on the final END cycle, which is also the last busy cycle.
    publish_s  = (state_n == ST_END) && (cnt_n == DIV_LAST);
    keys_new_s = map_keys(shift_r);
  end

  // Two-flop synchronizer for the asynchronous DIO pad input (idles high)
  always_ff @(posedge clk1) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= kif.dio_in;
      sync2_r <= sync1_r;
    end
  end

  // Registered link outputs, busy/valid and published scan results
  always_ff @(posedge clk1) begin
    if (!reset) begin
      stb_r       <= 1'b1;
      sclk_r      <= 1'b1;
      dio_out_r   <= 1'b0;
      dio_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      key_raw_r   <= 32'h0000_0000;
      keys_r      <= 8'h00;
      key_press_r <= 8'h00;
    end else begin
      stb_r     <= stb_n;
      sclk_r    <= sclk_n;
      dio_out_r <= dio_out_n;
      dio_oe_r  <= dio_oe_n;
      busy_r    <= busy_n;
      valid_r   <= publish_s;
      if (publish_s) begin
        key_raw_r   <= shift_r;
        keys_r      <= keys_new_s;
        key_press_r <= keys_new_s & ~keys_r;
      end else begin
        key_raw_r   <= key_raw_r;
        keys_r      <= keys_r;
        key_press_r <= 8'h00;
      end
    end
  end

  assign kif.stb       = stb_r;
  assign kif.sclk      = sclk_r;
  assign kif.dio_out   = dio_out_r;
  assign kif.dio_oe    = dio_oe_r;
  assign kif.busy      = busy_r;
  assign kif.valid     = valid_r;
  assign kif.key_raw   = key_raw_r;
  assign kif.keys      = keys_r;
  assign kif.key_press = key_press_r;

endmodule

// File: tb/tb_tm1638_keys.sv
// tb_tm1638_keys
// Self-checking bench for tm1638_keys: a TM1638 device model answers the
// read-key command with a chosen 32-bit response and records what it saw on
// the link; directed table vectors, hand-written corner sequences and random
// scans are compared against a button-level reference model.
module tb_tm1638_keys;

  localparam int CLK_DIV     = 4;
  localparam int WAIT_CYCLES = 8;
  localparam int SCAN_LEN    = 82 * CLK_DIV + WAIT_CYCLES;

  logic clk1 = 1'b0;
  logic reset;

  tm1638_keys_if bus ();

  tm1638_keys #(
    .CLK_DIV     (CLK_DIV),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk1  (clk1),
    .reset (reset),
    .kif   (bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: button b is bit 0 (b<4) or bit 4 (b>=4) of scan byte b%4.
  function automatic logic [7:0] ref_keys(input logic [31:0] word);
    logic [7:0] bytes [4];
    logic [7:0] k;
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    k = 8'h00;
    for (int b = 0; b < 8; b++) begin
      k[b] = bytes[b % 4][(b / 4) * 4];
    end
    return k;
  endfunction

  // ---------------- TM1638 device model / link monitor ----------------
  logic [31:0] resp_word;
  logic [7:0]  cmd_seen;
  int          rise_cnt;
  int          read_idx;
  int          low_pulses;
  int          low_len;
  int          cmd_width_err;
  int          stb_lead;
  int          stb_cyc;
  int          since8;
  int          oe_err;
  int          dio_chg_err;
  logic        prev_sclk;
  logic        prev_stb;
  logic        prev_dio;

  initial begin
    bus.dio_in    = 1'b1;
    prev_sclk     = 1'b1;
    prev_stb      = 1'b1;
    prev_dio      = 1'b0;
    rise_cnt      = 0;
    read_idx      = 0;
    low_pulses    = 0;
    low_len       = 0;
    cmd_width_err = 0;
    stb_lead      = -1;
    stb_cyc       = 0;
    since8        = 0;
    oe_err        = 0;
    dio_chg_err   = 0;
    cmd_seen      = 8'h00;
    forever begin
      @(negedge clk1);
      if (bus.stb === 1'b1) begin
        rise_cnt   = 0;
        read_idx   = 0;
        bus.dio_in = 1'b1;
      end else begin
        if (prev_stb === 1'b1) begin
          cmd_seen      = 8'h00;
          low_pulses    = 0;
          cmd_width_err = 0;
          stb_lead      = -1;
          stb_cyc       = 0;
          oe_err        = 0;
          dio_chg_err   = 0;
          since8        = 0;
        end
        // After the last command high phase the bus must be released.
        if (rise_cnt >= 8) begin
          since8 = since8 + 1;
          if (since8 >= CLK_DIV && bus.dio_oe !== 1'b0) oe_err = oe_err + 1;
        end
        if (prev_sclk === 1'b1 && bus.sclk === 1'b0) begin
          if (low_pulses == 0) stb_lead = stb_cyc;
          low_pulses = low_pulses + 1;
          low_len    = 1;
          if (rise_cnt >= 8 && read_idx < 32) begin
            bus.dio_in = resp_word[read_idx];
            read_idx   = read_idx + 1;
          end
        end else if (prev_sclk === 1'b0 && bus.sclk === 1'b0) begin
          low_len = low_len + 1;
        end else if (prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
          if (rise_cnt < 8) begin
            if (low_len != CLK_DIV) cmd_width_err = cmd_width_err + 1;
            cmd_seen[rise_cnt] = bus.dio_out;
            rise_cnt = rise_cnt + 1;
            if (rise_cnt == 8) since8 = 0;
          end
        end else if (bus.dio_oe === 1'b1 && prev_dio !== bus.dio_out) begin
          dio_chg_err = dio_chg_err + 1;
        end
        stb_cyc = stb_cyc + 1;
      end
      prev_sclk = bus.sclk;
      prev_stb  = bus.stb;
      prev_dio  = bus.dio_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk1);
    bus.start = 1'b1;
    @(negedge clk1);
    bus.start = 1'b0;
  endtask

  task automatic run_scan(input logic [31:0] word, input logic [7:0] exp_keys,
                          input logic [7:0] exp_press);
    int n;
    int busy_cyc;
    bit got;
    resp_word = word;
    pulse_start();
    n        = 1;
    busy_cyc = 0;
    got      = 1'b0;
    while (!got && n <= SCAN_LEN + 20) begin
      if (bus.busy === 1'b1) busy_cyc = busy_cyc + 1;
      if (bus.valid === 1'b1) begin
        got = 1'b1;
      end else begin
        @(negedge clk1);
        n = n + 1;
      end
    end
    check("valid_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(n), 32'(SCAN_LEN));
      check("busy_cycles", 32'(busy_cyc), 32'(SCAN_LEN));
      check("key_raw", bus.key_raw, word);
      check("keys", 32'(bus.keys), 32'(exp_keys));
      check("key_press", 32'(bus.key_press), 32'(exp_press));
      check("cmd_byte", 32'(cmd_seen), 32'h42);
      check("sclk_low_pulses", 32'(low_pulses), 32'd40);
      check("cmd_low_width", 32'(cmd_width_err), 32'd0);
      check("stb_lead", 32'(stb_lead), 32'(CLK_DIV));
      check("dio_oe_released", 32'(oe_err), 32'd0);
      check("dio_stable_high", 32'(dio_chg_err), 32'd0);
      @(negedge clk1);
      check("valid_pulse_len", 32'(bus.valid), 32'd0);
      check("key_press_cleared", 32'(bus.key_press), 32'd0);
      check("busy_after_valid", 32'(bus.busy), 32'd0);
      check("keys_hold", 32'(bus.keys), 32'(exp_keys));
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  keys;
    logic [7:0]  press;
  } vec_t;

  vec_t        vecs [7];
  logic [7:0]  ref_prev;
  logic [31:0] w;
  logic [7:0]  ek;
  int          n;
  int          vcount;
  int          first_v;
  int          vt [4];
  bit          saw_valid;

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    resp_word = 32'h0000_0000;
    ref_prev  = 8'h00;

    vecs[0] = '{32'h1100_1001, 8'hA9, 8'hA9};
    vecs[1] = '{32'h0000_0001, 8'h01, 8'h00};
    vecs[2] = '{32'h0000_0101, 8'h03, 8'h02};
    vecs[3] = '{32'h0000_0101, 8'h03, 8'h00};
    vecs[4] = '{32'hFFFF_FFFF, 8'hFF, 8'hFC};
    vecs[5] = '{32'hEEEE_EEEE, 8'h00, 8'h00};
    vecs[6] = '{32'h1010_1010, 8'hF0, 8'hF0};

    // Reset: held low for three edges
    repeat (3) @(negedge clk1);
    check("rst_stb", 32'(bus.stb), 32'd1);
    check("rst_sclk", 32'(bus.sclk), 32'd1);
    check("rst_dio_out", 32'(bus.dio_out), 32'd0);
    check("rst_dio_oe", 32'(bus.dio_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_key_raw", bus.key_raw, 32'd0);
    check("rst_keys", 32'(bus.keys), 32'd0);
    check("rst_key_press", 32'(bus.key_press), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      check("idle_stb", 32'(bus.stb), 32'd1);
      check("idle_sclk", 32'(bus.sclk), 32'd1);
    end

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_scan(vecs[i].word, vecs[i].keys, vecs[i].press);
      ref_prev = vecs[i].keys;
    end

    // Reset during READ bit 20
    resp_word = 32'h0000_0000;
    pulse_start();
    n         = 0;
    saw_valid = 1'b0;
    while (read_idx < 21 && n < SCAN_LEN) begin
      if (bus.valid === 1'b1) saw_valid = 1'b1;
      @(negedge clk1);
      n = n + 1;
    end
    check("abort_reached_bit20", 32'(read_idx >= 21), 32'd1);
    reset = 1'b0;
    @(negedge clk1);
    check("abort_stb", 32'(bus.stb), 32'd1);
    check("abort_sclk", 32'(bus.sclk), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dio_oe", 32'(bus.dio_oe), 32'd0);
    reset = 1'b1;
    for (int c = 0; c < SCAN_LEN + 20; c++) begin
      @(negedge clk1);
      if (bus.valid === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    ref_prev = 8'h00;
    run_scan(32'h0000_0000, 8'h00, 8'h00);

    // start pulsed again during CMD is ignored
    resp_word = 32'h0000_0101;
    pulse_start();
    vcount  = 0;
    first_v = 0;
    for (int c = 1; c <= 2 * SCAN_LEN; c++) begin
      bus.start = (c == 20) ? 1'b1 : 1'b0;
      if (bus.valid === 1'b1) begin
        vcount = vcount + 1;
        if (first_v == 0) first_v = c;
      end
      @(negedge clk1);
    end
    bus.start = 1'b0;
    check("busy_start_valids", 32'(vcount), 32'd1);
    check("busy_start_latency", 32'(first_v), 32'(SCAN_LEN));
    check("busy_start_keys", 32'(bus.keys), 32'h03);
    ref_prev = 8'h03;

    // start held high: back-to-back scans with one IDLE cycle between
    @(negedge clk1);
    bus.start = 1'b1;
    vcount    = 0;
    for (int c = 1; c <= 3 * (SCAN_LEN + 1) + 10; c++) begin
      @(negedge clk1);
      if (bus.valid === 1'b1) begin
        if (vcount < 4) vt[vcount] = c;
        vcount = vcount + 1;
      end
    end
    bus.start = 1'b0;
    check("held_valid_count", 32'(vcount), 32'd3);
    if (vcount >= 3) begin
      check("held_period_1", 32'(vt[1] - vt[0]), 32'(SCAN_LEN + 1));
      check("held_period_2", 32'(vt[2] - vt[1]), 32'(SCAN_LEN + 1));
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < SCAN_LEN + 10) begin
      @(negedge clk1);
      n = n + 1;
    end
    check("held_drain_idle", 32'(bus.busy), 32'd0);
    ref_prev = ref_keys(32'h0000_0101);

    // Random scans against the reference model
    for (int r = 0; r < 12; r++) begin
      w = $urandom;
      if (r % 3 == 0) w = w & $urandom;
      repeat ($urandom_range(0, 5)) @(negedge clk1);
      ek = ref_keys(w);
      run_scan(w, ek, ek & ~ref_prev);
      ref_prev = ek;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
